// File: rtl/clkgen_req_sequencer.sv
// Two-requester arbiter/sequencer in front of the MMCM reprogrammer: grants a
// profile change, pulses start, waits for done/locked, acks. Optional retry/timeout: CLKSEQ_TIMEOUT_EN.
module clkgen_req_sequencer #(
  parameter int unsigned START_LEN   = 7,
  parameter int unsigned TIMEOUT_CYC = 1048576,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] sel0,
  input  logic [1:0] sel1,
  output logic [1:0] ack,
  output logic       err,
  output logic       busy,
  output logic [1:0] cur_sel,
  output logic [7:0] cg_O,
  output logic [3:0] cg_D,
  output logic [6:0] cg_M,
  output logic       cg_start,
  input  logic       cg_done,
  input  logic       cg_locked
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] START_LAST = SW'(START_LEN - 1);

  typedef struct packed {
    logic [6:0] m;
    logic [3:0] d;
    logic [7:0] o;
  } profile_t;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_WAIT_LOCK, S_ACK
  } state_t;

  function automatic profile_t profile(input logic [1:0] s);
    profile_t p;
    p = '{m: 7'd7, d: 4'd4, o: 8'd100};
    case (s)
      2'd1:    p = '{m: 7'd35, d: 4'd8, o: 8'd125};
      2'd2:    p = '{m: 7'd7,  d: 4'd4, o: 8'd25};
      2'd3:    p = '{m: 7'd42, d: 4'd4, o: 8'd25};
      default: p = '{m: 7'd7,  d: 4'd4, o: 8'd100};
    endcase
    return p;
  endfunction

  state_t          state_q;
  profile_t        prof_q;
  logic [SW-1:0]   start_cnt_q;
  logic [1:0]      ack_q, sel_q, cur_sel_q;
  logic            busy_q, cg_start_q, gnt_q, rr_q, applied_q;

  logic            gnt_idx_c, fast_c;
  logic [1:0]      gnt_sel_c;

  // Round-robin pick when both request; rr_q names the favoured requester.
  always_comb begin
    gnt_idx_c = (req == 2'b11) ? rr_q : req[1];
    gnt_sel_c = gnt_idx_c ? sel1 : sel0;
    fast_c    = applied_q && cg_locked && (gnt_sel_c == cur_sel_q);
  end

`ifdef CLKSEQ_TIMEOUT_EN
  localparam int unsigned TW = 20;
  localparam int unsigned RW = 4;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_q;
  logic [RW-1:0] retry_q;
  logic          err_q;
  logic          tmo_hit_c;

  assign tmo_hit_c = (tmo_q == TMO_LAST);
  assign err       = err_q;
`else
  logic unused_cfg_c;
  assign unused_cfg_c = ^{TIMEOUT_CYC, MAX_RETRY};
  assign err          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      prof_q      <= profile(2'd0);
      start_cnt_q <= '0;
      ack_q       <= '0;
      sel_q       <= '0;
      cur_sel_q   <= '0;
      busy_q      <= 1'b0;
      cg_start_q  <= 1'b0;
      gnt_q       <= 1'b0;
      rr_q        <= 1'b0;
      applied_q   <= 1'b0;
`ifdef CLKSEQ_TIMEOUT_EN
      tmo_q       <= '0;
      retry_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (cg_done && (req != 2'b00)) begin
            busy_q <= 1'b1;
            gnt_q  <= gnt_idx_c;
            sel_q  <= gnt_sel_c;
            rr_q   <= ~gnt_idx_c;
            prof_q <= profile(gnt_sel_c);
`ifdef CLKSEQ_TIMEOUT_EN
            err_q   <= 1'b0;
            retry_q <= '0;
`endif
            if (fast_c) begin
              ack_q   <= gnt_idx_c ? 2'b10 : 2'b01;
              state_q <= S_ACK;
            end else begin
              cg_start_q  <= 1'b1;
              start_cnt_q <= START_LAST;
              state_q     <= S_START;
            end
          end
        end
        S_START: begin
          if (start_cnt_q == '0) begin
            cg_start_q <= 1'b0;
            state_q    <= S_WAIT_BUSY;
          end else begin
            start_cnt_q <= start_cnt_q - SW'(1);
          end
        end
        S_WAIT_BUSY: begin
          if (!cg_done) begin
            state_q <= S_WAIT_DONE;
`ifdef CLKSEQ_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        S_WAIT_DONE: begin
          if (cg_done) state_q <= S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (cg_locked) begin
            ack_q     <= gnt_q ? 2'b10 : 2'b01;
            cur_sel_q <= sel_q;
            applied_q <= 1'b1;
            state_q   <= S_ACK;
          end
        end
        S_ACK: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef CLKSEQ_TIMEOUT_EN
      // Timeout overrides the waits; a lock in the same cycle still wins.
      if ((state_q == S_WAIT_DONE) || ((state_q == S_WAIT_LOCK) && !cg_locked)) begin
        if (tmo_hit_c) begin
          if (retry_q == RW'(MAX_RETRY)) begin
            ack_q     <= gnt_q ? 2'b10 : 2'b01;
            err_q     <= 1'b1;
            applied_q <= 1'b0;
            state_q   <= S_ACK;
          end else begin
            retry_q     <= retry_q + RW'(1);
            cg_start_q  <= 1'b1;
            start_cnt_q <= START_LAST;
            state_q     <= S_START;
          end
        end else if (tmo_q != '1) begin
          tmo_q <= tmo_q + TW'(1);
        end
      end
`endif
    end
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign cur_sel  = cur_sel_q;
  assign cg_M     = prof_q.m;
  assign cg_D     = prof_q.d;
  assign cg_O     = prof_q.o;
  assign cg_start = cg_start_q;

endmodule
